// File: rtl/regfile_arbiter_pkg.sv
// rtl/regfile_arbiter_pkg.sv - shared word width, register-file mode encodings and port ids
package regfile_arbiter_pkg;

  localparam int WORD = 16;

  // Register-file port modes; idle must stay distinct from in/out.
  localparam logic [1:0] REG_MODE_IDLE = 2'b00;
  localparam logic [1:0] REG_MODE_IN   = 2'b01;
  localparam logic [1:0] REG_MODE_OUT  = 2'b10;

  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_port_e;

endpackage

// File: rtl/regfile_arbiter_rr_pick2.sv
// rtl/regfile_arbiter_rr_pick2.sv - two-way round-robin picker owning the read-port pointer
module regfile_arbiter_rr_pick2
  import regfile_arbiter_pkg::*;
(
  input  logic clk,
  input  logic clear_n,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  rr_port_e rr_ptr;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      if (rr_ptr == RR_A) begin
        if (req_a)      gnt_a = 1'b1;
        else if (req_b) gnt_b = 1'b1;
      end else begin
        if (req_b)      gnt_b = 1'b1;
        else if (req_a) gnt_a = 1'b1;
      end
    end
  end

  // Point at the port that lost (or was absent) so the next contest favours it.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      rr_ptr <= RR_A;
    end else if (gnt_a) begin
      rr_ptr <= RR_B;
    end else if (gnt_b) begin
      rr_ptr <= RR_A;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - single-port register file access arbiter (writeback + two read ports)
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int MAX_WR_BURST = 4,
  parameter int PROT_REGS    = 4
) (
  input  logic            clk,
  input  logic            clear_n,
  input  logic            wr_req,
  input  logic [5:0]      wr_sel,
  input  logic [WORD-1:0] wr_data,
  output logic            wr_gnt,
  output logic            wr_err,
  input  logic            ra_req,
  input  logic [5:0]      ra_sel,
  output logic            ra_gnt,
  output logic            ra_valid,
  output logic [WORD-1:0] ra_data,
  input  logic            rb_req,
  input  logic [5:0]      rb_sel,
  output logic            rb_gnt,
  output logic            rb_valid,
  output logic [WORD-1:0] rb_data,
  output logic [1:0]      rf_mode,
  output logic [5:0]      rf_sel,
  output logic [WORD-1:0] rf_data_in,
  input  logic [WORD-1:0] rf_data_out
);

  logic [3:0] burst_cnt;
  logic       read_pending;
  logic       burst_full;
  logic       wr_prot;
  logic       rd_en;

  assign read_pending = ra_req | rb_req;
  assign burst_full   = (burst_cnt == 4'(MAX_WR_BURST));
  assign wr_prot      = ({1'b0, wr_sel} < 7'(PROT_REGS));

  // Grants are forced low during reset so nothing reaches the file.
  assign wr_gnt = clear_n & wr_req & ~(burst_full & read_pending);
  assign rd_en  = clear_n & ~wr_gnt;

  regfile_arbiter_rr_pick2 u_rr_pick2 (
    .clk     (clk),
    .clear_n (clear_n),
    .en      (rd_en),
    .req_a   (ra_req),
    .req_b   (rb_req),
    .gnt_a   (ra_gnt),
    .gnt_b   (rb_gnt)
  );

  always_comb begin
    rf_mode    = REG_MODE_IDLE;
    rf_sel     = 6'd0;
    rf_data_in = '0;
    if (wr_gnt) begin
      rf_sel     = wr_sel;
      rf_data_in = wr_data;
      rf_mode    = wr_prot ? REG_MODE_IDLE : REG_MODE_IN;
    end else if (ra_gnt) begin
      rf_mode = REG_MODE_OUT;
      rf_sel  = ra_sel;
    end else if (rb_gnt) begin
      rf_mode = REG_MODE_OUT;
      rf_sel  = rb_sel;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      burst_cnt <= 4'd0;
      ra_valid  <= 1'b0;
      rb_valid  <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      ra_valid <= ra_gnt;
      rb_valid <= rb_gnt;
      wr_err   <= wr_gnt & wr_prot;
      if (ra_gnt | rb_gnt | ~read_pending) begin
        burst_cnt <= 4'd0;
      end else if (wr_gnt && !burst_full) begin
        burst_cnt <= burst_cnt + 4'd1;
      end
    end
  end

  assign ra_data = rf_data_out;
  assign rb_data = rf_data_out;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - directed vector bench for regfile_arbiter with a register-file model
module tb_regfile_arbiter;
  import regfile_arbiter_pkg::*;

  logic            clk = 1'b0;
  logic            clear_n;
  logic            wr_req, ra_req, rb_req;
  logic [5:0]      wr_sel, ra_sel, rb_sel;
  logic [WORD-1:0] wr_data;
  logic            wr_gnt, wr_err, ra_gnt, rb_gnt, ra_valid, rb_valid;
  logic [WORD-1:0] ra_data, rb_data;
  logic [1:0]      rf_mode;
  logic [5:0]      rf_sel;
  logic [WORD-1:0] rf_data_in;
  logic [WORD-1:0] rf_data_out;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_arbiter #(.MAX_WR_BURST(4), .PROT_REGS(4)) dut (
    .clk(clk), .clear_n(clear_n),
    .wr_req(wr_req), .wr_sel(wr_sel), .wr_data(wr_data), .wr_gnt(wr_gnt), .wr_err(wr_err),
    .ra_req(ra_req), .ra_sel(ra_sel), .ra_gnt(ra_gnt), .ra_valid(ra_valid), .ra_data(ra_data),
    .rb_req(rb_req), .rb_sel(rb_sel), .rb_gnt(rb_gnt), .rb_valid(rb_valid), .rb_data(rb_data),
    .rf_mode(rf_mode), .rf_sel(rf_sel), .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
  );

  always #5 clk = ~clk;

  // Register file: synchronous write, registered read.
  logic [WORD-1:0] mem [64];
  always @(posedge clk) begin
    if (rf_mode == REG_MODE_IN)       mem[rf_sel] <= rf_data_in;
    else if (rf_mode == REG_MODE_OUT) rf_data_out <= mem[rf_sel];
  end

  typedef struct {
    logic        wr_req; logic [5:0] wr_sel; logic [15:0] wr_data;
    logic        ra_req; logic [5:0] ra_sel;
    logic        rb_req; logic [5:0] rb_sel;
    logic        e_wg; logic e_ag; logic e_bg;
    logic [1:0]  e_mode; logic [5:0] e_sel; logic [15:0] e_din;
    logic        e_rav; logic e_rbv; logic e_err; logic [15:0] e_rdata;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    wr_req = 1'b0; wr_sel = 6'd0; wr_data = '0;
    ra_req = 1'b0; ra_sel = 6'd0;
    rb_req = 1'b0; rb_sel = 6'd0;
  endtask

  function automatic vec_t mk(
    input logic wq, input logic [5:0] ws, input logic [15:0] wd,
    input logic aq, input logic [5:0] as_, input logic bq, input logic [5:0] bs,
    input logic wg, input logic ag, input logic bg,
    input logic [1:0] md, input logic [5:0] sl, input logic [15:0] di,
    input logic rav, input logic rbv, input logic er, input logic [15:0] rd);
    vec_t v;
    v.wr_req = wq; v.wr_sel = ws; v.wr_data = wd;
    v.ra_req = aq; v.ra_sel = as_; v.rb_req = bq; v.rb_sel = bs;
    v.e_wg = wg; v.e_ag = ag; v.e_bg = bg;
    v.e_mode = md; v.e_sel = sl; v.e_din = di;
    v.e_rav = rav; v.e_rbv = rbv; v.e_err = er; v.e_rdata = rd;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0A00 + 16'(i);
    mem[0] = 16'h0000; mem[1] = 16'h0001; mem[2] = 16'h8000; mem[3] = 16'hffff;
    rf_data_out = '0;

    //              wq ws  wd       aq as  bq bs   wg ag bg mode           sel din      rav rbv err rdata
    tbl[0]  = mk(0, 0,  16'h0,    1, 8,  0, 0,   0, 1, 0, REG_MODE_OUT,  8,  16'h0,    0, 0, 0, 16'h0);
    tbl[1]  = mk(0, 0,  16'h0,    0, 0,  0, 0,   0, 0, 0, REG_MODE_IDLE, 0,  16'h0,    1, 0, 0, 16'h0A08);
    tbl[2]  = mk(1, 10, 16'h1234, 0, 0,  0, 0,   1, 0, 0, REG_MODE_IN,   10, 16'h1234, 0, 0, 0, 16'h0);
    tbl[3]  = mk(0, 0,  16'h0,    1, 10, 0, 0,   0, 1, 0, REG_MODE_OUT,  10, 16'h0,    0, 0, 0, 16'h0);
    tbl[4]  = mk(0, 0,  16'h0,    0, 0,  0, 0,   0, 0, 0, REG_MODE_IDLE, 0,  16'h0,    1, 0, 0, 16'h1234);
    tbl[5]  = mk(1, 2,  16'h0,    0, 0,  0, 0,   1, 0, 0, REG_MODE_IDLE, 2,  16'h0,    0, 0, 0, 16'h0);
    tbl[6]  = mk(0, 0,  16'h0,    0, 0,  0, 0,   0, 0, 0, REG_MODE_IDLE, 0,  16'h0,    0, 0, 1, 16'h0);
    tbl[7]  = mk(0, 0,  16'h0,    0, 0,  1, 2,   0, 0, 1, REG_MODE_OUT,  2,  16'h0,    0, 0, 0, 16'h0);
    tbl[8]  = mk(0, 0,  16'h0,    0, 0,  0, 0,   0, 0, 0, REG_MODE_IDLE, 0,  16'h0,    0, 1, 0, 16'h8000);
    tbl[9]  = mk(1, 3,  16'h0005, 1, 1,  0, 0,   1, 0, 0, REG_MODE_IDLE, 3,  16'h0005, 0, 0, 0, 16'h0);
    tbl[10] = mk(0, 0,  16'h0,    1, 1,  0, 0,   0, 1, 0, REG_MODE_OUT,  1,  16'h0,    0, 0, 1, 16'h0);
    tbl[11] = mk(0, 0,  16'h0,    0, 0,  0, 0,   0, 0, 0, REG_MODE_IDLE, 0,  16'h0,    1, 0, 0, 16'h0001);

    // Reset: requests present but nothing granted, state cleared.
    clear_n = 1'b0;
    drive_idle();
    ra_req = 1'b1; ra_sel = 6'd8; wr_req = 1'b1; wr_sel = 6'd9;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_wr_gnt", 32'(wr_gnt), 32'd0);
    chk("rst_ra_gnt", 32'(ra_gnt), 32'd0);
    chk("rst_mode", 32'(rf_mode), 32'(REG_MODE_IDLE));
    chk("rst_ra_valid", 32'(ra_valid), 32'd0);
    chk("rst_rb_valid", 32'(rb_valid), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    chk("rst_burst", 32'(dut.burst_cnt), 32'd0);
    chk("rst_rr_ptr", 32'(dut.u_rr_pick2.rr_ptr), 32'(RR_A));
    drive_idle();
    clear_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      wr_req = tbl[i].wr_req; wr_sel = tbl[i].wr_sel; wr_data = tbl[i].wr_data;
      ra_req = tbl[i].ra_req; ra_sel = tbl[i].ra_sel;
      rb_req = tbl[i].rb_req; rb_sel = tbl[i].rb_sel;
      #1;
      chk($sformatf("v%0d_wr_gnt", i), 32'(wr_gnt), 32'(tbl[i].e_wg));
      chk($sformatf("v%0d_ra_gnt", i), 32'(ra_gnt), 32'(tbl[i].e_ag));
      chk($sformatf("v%0d_rb_gnt", i), 32'(rb_gnt), 32'(tbl[i].e_bg));
      chk($sformatf("v%0d_rf_mode", i), 32'(rf_mode), 32'(tbl[i].e_mode));
      chk($sformatf("v%0d_rf_sel", i), 32'(rf_sel), 32'(tbl[i].e_sel));
      chk($sformatf("v%0d_rf_data_in", i), 32'(rf_data_in), 32'(tbl[i].e_din));
      chk($sformatf("v%0d_ra_valid", i), 32'(ra_valid), 32'(tbl[i].e_rav));
      chk($sformatf("v%0d_rb_valid", i), 32'(rb_valid), 32'(tbl[i].e_rbv));
      chk($sformatf("v%0d_wr_err", i), 32'(wr_err), 32'(tbl[i].e_err));
      if (tbl[i].e_rav) chk($sformatf("v%0d_ra_data", i), 32'(ra_data), 32'(tbl[i].e_rdata));
      if (tbl[i].e_rbv) chk($sformatf("v%0d_rb_data", i), 32'(rb_data), 32'(tbl[i].e_rdata));
    end

    // Contested reads from a fresh pointer: A, B, A, B, A, B.
    @(negedge clk);
    drive_idle();
    clear_n = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ra_req = 1'b1; ra_sel = 6'd11;
      rb_req = 1'b1; rb_sel = 6'd12;
      #1;
      chk($sformatf("rr%0d_ra_gnt", i), 32'(ra_gnt), 32'((i % 2) == 0));
      chk($sformatf("rr%0d_rb_gnt", i), 32'(rb_gnt), 32'((i % 2) == 1));
      if (i > 0) begin
        chk($sformatf("rr%0d_ra_valid", i), 32'(ra_valid), 32'((i % 2) == 1));
        chk($sformatf("rr%0d_rb_data", i), 32'((i % 2) == 0 ? rb_data : ra_data),
            32'((i % 2) == 0 ? 16'h0A0C : 16'h0A0B));
      end
    end
    @(negedge clk);
    drive_idle();
    #1;
    chk("rr_last_rb_valid", 32'(rb_valid), 32'd1);

    // Write burst limit: 4 writes, 1 read, 4 writes, 1 read.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      wr_req = 1'b1; wr_sel = 6'd20; wr_data = 16'h5000 + 16'(i);
      ra_req = 1'b1; ra_sel = 6'd5;
      #1;
      chk($sformatf("burst%0d_wr_gnt", i), 32'(wr_gnt), 32'(!(i == 4 || i == 9)));
      chk($sformatf("burst%0d_ra_gnt", i), 32'(ra_gnt), 32'(i == 4 || i == 9));
      if (i == 4) chk("burst_cnt_full", 32'(dut.burst_cnt), 32'd4);
      if (i == 5) chk("burst_cnt_cleared", 32'(dut.burst_cnt), 32'd0);
      if (i == 5) chk("burst_read_data", 32'(ra_data), 32'h0A05);
    end
    @(negedge clk);
    drive_idle();
    #1;
    chk("burst_write_landed", 32'(mem[20]), 32'h5008);

    // Reset arriving during a read grant drops that read.
    @(negedge clk);
    ra_req = 1'b1; ra_sel = 6'd8;
    #1;
    chk("midrst_gnt_before", 32'(ra_gnt), 32'd1);
    #2;
    clear_n = 1'b0;
    #1;
    chk("midrst_gnt_during", 32'(ra_gnt), 32'd0);
    chk("midrst_mode_during", 32'(rf_mode), 32'(REG_MODE_IDLE));
    @(negedge clk);
    ra_req = 1'b0;
    #1;
    chk("midrst_valid_in_reset", 32'(ra_valid), 32'd0);
    clear_n = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_valid_after", 32'(ra_valid), 32'd0);
    chk("midrst_rr_ptr", 32'(dut.u_rr_pick2.rr_ptr), 32'(RR_A));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Single-port access controller for the 64 × `WORD` register file. It shares the file's one `reg_sel`/`mode` port between three requesters: a writeback write port and two operand read ports, A and B. Each cycle it grants at most one access, with writeback priority bounded by a burst limit and round-robin between the read ports. It sits between decode/writeback and the register file, drives the file's `mode`/`reg_sel`/`data_in`, and returns read data with a valid strobe.

## Interface
Parameters:
- `MAX_WR_BURST`, 4: maximum consecutive write grants while any read is pending; range 1–15.
- `PROT_REGS`, 4: registers 0..PROT_REGS-1 hold constants (0, 1, 16'h8000, 16'hffff) and are write-protected.

Ports:
- `clk`  in  1  — single clock; all state updates on posedge.
- `clear_n`  in  1  — asynchronous, active-low reset.
- `wr_req`  in  1  — writeback request; `wr_sel` and `wr_data` held stable until `wr_gnt`.
- `wr_sel`  in  6  — destination register.
- `wr_data`  in  `WORD` — write value.
- `wr_gnt`  out  1  — combinational; write is accepted at this cycle's posedge.
- `wr_err`  out  1  — registered one-cycle pulse; the accepted write targeted a protected register and was dropped.
- `ra_req`, `rb_req`  in  1  — read requests; the matching sel is held until grant.
- `ra_sel`, `rb_sel`  in  6  — source register.
- `ra_gnt`, `rb_gnt`  out  1  — combinational grant.
- `ra_valid`, `rb_valid`  out  1  — registered; the data is valid this cycle.
- `ra_data`, `rb_data`  out  `WORD` — equal to `rf_data_out`; meaningful only while the matching valid is high.
- `rf_mode`  out  2  — to register file `mode`: `regModeIn`, `regModeOut` or `regModeIdle`.
- `rf_sel`  out  6  — to `reg_sel`.
- `rf_data_in`  out  `WORD` — to `data_in`.
- `rf_data_out`  in  `WORD` — from `data_out`.

## Operation
- **Arbitration**, evaluated every cycle:
  - Grant write if `wr_req` is high and not (`burst_cnt` == MAX_WR_BURST and a read is pending).
  - Otherwise, grant the pending read port indicated by `rr_ptr`.
  - Otherwise, grant the other pending read port.
  - At most one grant is high in any cycle.
- **Burst counter** `burst_cnt`, 4 bits:
  - A write grant while a read is pending increments it, saturating at MAX_WR_BURST.
  - Any read grant, or any cycle with no read pending, clears it to 0.
- **Round-robin pointer** `rr_ptr`: after a read grant it points to the port that was *not* granted. An uncontested read leaves the pointer flipped as well.
- **Write grant:**
  - `rf_mode`=`regModeIn`, `rf_sel`=`wr_sel`, `rf_data_in`=`wr_data`.
  - If `wr_sel` < PROT_REGS: `rf_mode`=`regModeIdle` instead, and `wr_err` pulses the next cycle. The grant is still given so the requester does not stall.
- **Read grant:** `rf_mode`=`regModeOut`, `rf_sel`=the granted sel. The register file captures the value at the posedge, and the matching `*_valid` is high for exactly the following cycle.
- **No grant:** `rf_mode`=`regModeIdle`. `rf_sel` and `rf_data_in` are don't-care but held at 0.
- **Write then read of the same register:** resolved by serialization. The write is granted first, so the read returns the new value.

## Timing
- **Reset** (`clear_n` low):
  - `*_gnt`=0 and `rf_mode`=`regModeIdle`, combinationally.
  - `ra_valid`=`rb_valid`=`wr_err`=0, `burst_cnt`=0, `rr_ptr`=A, all asynchronously.
  - A grant in progress when reset asserts is discarded; no valid is produced for it.
- **Read latency:** grant in cycle N → data valid in cycle N+1.
- **Write:** takes effect at the posedge ending the grant cycle.
- **Throughput:** one access per cycle. Back-to-back grants are permitted, including alternating ports.
- **Request rules:** a requester may drop `req` only after its grant. Dropping it earlier is a protocol violation; the outcome is undefined but must not corrupt other ports.

## Structure
- `regModeIdle` is added to `signals.v`, with an encoding distinct from `regModeIn` and `regModeOut`. The block uses only these macros and `WORD`.
- One natural sub-module, `rr_pick2`: a two-way round-robin picker holding `rr_ptr`.
- Burst counting and the protection check stay in the top module.

## Test plan
- **Reset:** reset values from the Timing section; then `ra_req`, `ra_sel`=8 → `ra_gnt` in the same cycle, `rf_mode`=`regModeOut`, `rf_sel`=8, `ra_valid` the next cycle with `ra_data`=register 8.
- **Write then read:** write 16'h1234 to register 10, then read register 10 on port A → granted on consecutive cycles, `ra_data`=16'h1234.
- **Protected write:** `wr_sel`=2, `wr_data`=0 → `wr_gnt`=1, `rf_mode`=`regModeIdle`, `wr_err` pulses; a later read of register 2 returns 16'h8000.
- **Contested reads:** `ra_req` and `rb_req` held high for 6 cycles → grants alternate A, B, A, B, A, B.
- **Write starvation bound:** `wr_req` held high continuously with `ra_req` high → 4 write grants, 1 read grant, then 4 more writes; `burst_cnt` returns to 0 after the read.
- **Reset mid-read:** `clear_n` asserted in a read-grant cycle → no `ra_valid` after reset release, `rr_ptr`=A.
